// File: rtl/accum_drain.sv
// Drains accumulator rows through a round/shift/saturate quantizer onto a valid/ready stream.
// Optional build macro ACCUM_DRAIN_RELU_EN zeroes negative partial sums before quantization.
module accum_drain #(
    parameter  int ACCUM_ROW  = 256,
    parameter  int DATA_WIDTH = 32,
    parameter  int OUT_WIDTH  = 8,
    localparam int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_rows,
    input  logic [4:0]            shift,
    output logic                  busy,
    output logic                  done,
    output logic                  acc_rd_en,
    output logic [ADDR_WIDTH-1:0] acc_rd_addr,
    input  logic [DATA_WIDTH-1:0] acc_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] ROWS_MAX  = (ADDR_WIDTH + 1)'(ACCUM_ROW);
    localparam logic [4:0]          SHIFT_MAX = 5'(DATA_WIDTH - 1);
    localparam logic signed [DATA_WIDTH:0] SAT_MAX = (DATA_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [DATA_WIDTH:0] SAT_MIN = -SAT_MAX - (DATA_WIDTH + 1)'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [4:0]            shift_q;

    logic [ADDR_WIDTH:0]          rows_clamped;
    logic [4:0]                   shift_clamped;
    logic signed [DATA_WIDTH:0]   q_ext;
    logic signed [DATA_WIDTH:0]   q_inc;
    logic signed [DATA_WIDTH:0]   q_shr;
    logic [OUT_WIDTH-1:0]         q_out;

    assign rows_clamped  = (num_rows > ROWS_MAX) ? ROWS_MAX : num_rows;
    assign shift_clamped = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;

    // A new row may load whenever the output register is empty or draining this cycle.
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign acc_rd_en   = (state == S_READ) && (!out_valid || out_ready);
    assign acc_rd_addr = (state == S_READ) ? addr_q : '0;

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        q_ext = {acc_rd_data[DATA_WIDTH-1], acc_rd_data};
`ifdef ACCUM_DRAIN_RELU_EN
        if (acc_rd_data[DATA_WIDTH-1]) q_ext = '0;
`endif
        q_inc = '0;
        if (shift_q != 5'd0) q_inc[shift_q - 5'd1] = 1'b1;
        q_shr = (q_ext + q_inc) >>> shift_q;
        q_out = q_shr[OUT_WIDTH-1:0];
        if (q_shr > SAT_MAX)      q_out = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        else if (q_shr < SAT_MIN) q_out = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            shift_q     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q      <= '0;
                        shift_q     <= shift_clamped;
                        last_addr_q <= ADDR_WIDTH'(rows_clamped - (ADDR_WIDTH + 1)'(1));
                        state       <= (rows_clamped == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (acc_rd_en) begin
                        out_data  <= q_out;
                        out_valid <= 1'b1;
                        out_last  <= (addr_q == last_addr_q);
                        addr_q    <= addr_q + ADDR_WIDTH'(1);
                        if (addr_q == last_addr_q) state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/accum_drain.md
# accum_drain

Readout stage directly downstream of the accumulator column. On a start pulse it reads a programmed number of accumulator rows in ascending address order through the column's combinational read port. It rounds, right-shifts and saturates each 32-bit partial sum to an output-width activation. Results are streamed to the output buffer over a valid/ready interface, one row per cycle when not back-pressured.

## Interface
- `ACCUM_ROW`, 256: rows in the accumulator column.
- `DATA_WIDTH`, 32: accumulator word width, signed two's complement.
- `OUT_WIDTH`, 8: output activation width, signed.
- `ADDR_WIDTH`, localparam `$clog2(ACCUM_ROW)`.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; accepted only in IDLE.
- `num_rows`  in  ADDR_WIDTH+1  rows to drain, sampled with `start`.
- `shift`  in  5  right-shift amount, sampled with `start`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last output handshake.
- `acc_rd_en`  out  1  accumulator read enable.
- `acc_rd_addr`  out  ADDR_WIDTH  accumulator read address.
- `acc_rd_data`  in  DATA_WIDTH  accumulator read data, valid in the same cycle as `acc_rd_en`.
- `out_valid`  out  1  `out_data` holds a valid result.
- `out_ready`  in  1  consumer accepts data when `out_valid` and `out_ready` are both high.
- `out_data`  out  OUT_WIDTH  quantized row result.
- `out_last`  out  1  qualifies the final row of the drain.

## Operation
- States: IDLE, READ, FLUSH, DONE.
- IDLE to READ when `start` is high and the clamped `num_rows` is > 0. `num_rows` clamps to `ACCUM_ROW`; `shift` clamps to `DATA_WIDTH-1`.
- IDLE to DONE when `start` is high and `num_rows` is 0. No read and no output occur.
- READ: `acc_rd_en` = slot_free, where slot_free = !`out_valid` || `out_ready`.
  - Each cycle with `acc_rd_en` high loads the single output register from `acc_rd_data` and increments the address.
  - With the last address read, `out_last` is loaded as 1 and the state moves to FLUSH.
- FLUSH: stays until the final handshake, then moves to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- `start` while `busy` is ignored.
- `out_data`, `out_last` and `out_valid` hold stable while `out_valid` is high and `out_ready` is low.
- `out_valid` deasserts after a handshake unless a new row loads in the same cycle.
- Quantize, evaluated combinationally on `acc_rd_data` before the register and carried at DATA_WIDTH+1 bits:
  - when `shift` > 0, add 2^(`shift`-1) (round half up);
  - arithmetic right shift by `shift`;
  - saturate to the range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- `acc_rd_addr` is 0 whenever not in READ.

## Timing
- Reset values: `busy`=0, `done`=0, `acc_rd_en`=0, `acc_rd_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0. State is IDLE.
- `start` sampled in cycle 0 gives READ in cycle 1: `acc_rd_en`=1 and `acc_rd_addr`=0.
- `out_valid` rises in cycle 2 carrying row 0. Read-to-output latency is 1 cycle.
- With `out_ready` held high, row k appears in cycle k+2.
- The last row N-1 appears in cycle N+1 with `out_last`=1, and `done` pulses in cycle N+2.
- Total drain without stalls is N+3 cycles from `start` to IDLE.
- Each stall cycle (`out_valid` high, `out_ready` low) suppresses `acc_rd_en` and holds the address, adding exactly one cycle.
- `rst` asserted mid-operation immediately forces all reset values, discards in-flight data and returns to IDLE. No `done` pulse is produced.

## Configuration
- `ACCUM_DRAIN_RELU_EN` defined: negative `acc_rd_data` is replaced by 0 before rounding, so `out_data` is never negative.
- `ACCUM_DRAIN_RELU_EN` undefined: signed quantization as described, with no clamp at zero.

## Test plan
- Reset then `start`, `num_rows`=4, `shift`=0, `out_ready`=1, rows {1,-2,127,128}:
  - `out_data` 1, -2, 127, 127 in cycles 2–5;
  - `out_last` high in cycle 5 only;
  - `done` high in cycle 6.
- `shift`=4, rows {24, 23, -24, 100000}:
  - outputs 2, 1, -1, 127;
  - 24+8=32 then >>4 gives 2; -24+8=-16 then >>4 gives -1.
- `num_rows`=3, `out_ready` low for cycles 2–4:
  - row 0 holds on `out_data` in cycles 2–4;
  - `acc_rd_addr` stays at 1 with `acc_rd_en`=0;
  - `done` in cycle 8.
- `num_rows`=0 and `start`: `done` pulses in cycle 1, with no `acc_rd_en` and no `out_valid`. A `start` while `busy` is high is ignored.
- `num_rows`=300, `ACCUM_ROW`=256: exactly 256 outputs, addresses 0–255.
- `rst` pulse in cycle 3 of an 8-row drain: all outputs 0 next cycle and no `done`. A following `start` restarts at address 0.
- With `ACCUM_DRAIN_RELU_EN` defined, row -50 outputs 0; without it, -50 outputs -50 at `shift`=0.
